// File: rtl/sh7604_ibus_ctrl.sv
// -----------------------------------------------------------------------------
// sh7604_ibus_ctrl
//
// Access controller for the SH7604 on-chip peripheral bus (IBUS). It takes one
// CPU access at a time, broadcasts it to NUM_PER peripheral slots and sequences
// the REQ/BUSY/ACT handshake. A write commits when the slot sees IBUS_REQ
// fall. Read data is taken from the lowest-index slot reporting ACT.
//
// Sequence, one CE_R tick per step: IDLE -> REQ -> WAIT (n ticks) -> DONE -> IDLE.
//
// Optional build macro:
//   IBUS_TIMEOUT_EN  abort a WAIT that lasts TIMEOUT_CYC ticks with the selected
//                    slot still busy. When undefined, WAIT waits indefinitely.
//
// Ports
//   CLK, RST_N         clock, asynchronous active-low reset
//   CE_R / CE_F        rising / falling phase enables; the FSM advances on CE_R only
//   EN                 global enable; the FSM and IBUS_REQ freeze while low
//   RES_N              synchronous soft reset, active low, not gated by CE_R/EN
//   CPU_A/DI/BA/WE/REQ CPU access request (REQ held until CPU_BUSY is seen low)
//   CPU_DO/BUSY/ERR    read data, stall, one-tick error pulse in the DONE tick
//   IBUS_A/DI/BA/WE    latched access, stable while IBUS_REQ is high
//   IBUS_REQ           request broadcast to all slots
//   PER_DO/BUSY/ACT    per-slot read data (packed 32 bits per slot), busy, decode hit
// -----------------------------------------------------------------------------
module sh7604_ibus_ctrl #(
  parameter int NUM_PER     = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  CE_R,
  input  logic                  CE_F,
  input  logic                  EN,
  input  logic                  RES_N,
  input  logic [31:0]           CPU_A,
  input  logic [31:0]           CPU_DI,
  input  logic [3:0]            CPU_BA,
  input  logic                  CPU_WE,
  input  logic                  CPU_REQ,
  output logic [31:0]           CPU_DO,
  output logic                  CPU_BUSY,
  output logic                  CPU_ERR,
  output logic [31:0]           IBUS_A,
  output logic [31:0]           IBUS_DI,
  output logic [3:0]            IBUS_BA,
  output logic                  IBUS_WE,
  output logic                  IBUS_REQ,
  input  logic [32*NUM_PER-1:0] PER_DO,
  input  logic [NUM_PER-1:0]    PER_BUSY,
  input  logic [NUM_PER-1:0]    PER_ACT
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state;
  logic        err_pend;   // a multi-hit was seen on an earlier WAIT tick
  logic [31:0] sel_do;
  logic        sel_busy;
  logic        sel_found;
  logic        hit_any;
  logic        hit_multi;

  // CE_F is part of the slot interface only; nothing in here runs on it.
  logic unused_ce_f;
  assign unused_ce_f = CE_F;

`ifdef IBUS_TIMEOUT_EN
  // Abort on the WAIT tick where the count of busy ticks reaches TIMEOUT_CYC.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] wait_cnt;
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT_CYC);
`endif

  // Lowest-index ACT wins when several slots decode the same address.
  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    sel_do    = '0;
    sel_busy  = 1'b0;
    sel_found = 1'b0;
    for (int i = 0; i < NUM_PER; i++) begin
      if (PER_ACT[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_do    = PER_DO[32*i +: 32];
        sel_busy  = PER_BUSY[i];
      end
    end
  end

  assign hit_any   = |PER_ACT;
  assign hit_multi = |(PER_ACT & (PER_ACT - NUM_PER'(1)));

  // The CPU is stalled from the request until the DONE tick, so it never sees
  // a free cycle before its access has completed.
  assign CPU_BUSY = (CPU_REQ && (state != S_DONE)) || (state == S_REQ) || (state == S_WAIT);

  // NOTE: sequential state uses non-blocking assignments only, so every branch
  // below reads the values from before this edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= S_IDLE;
      err_pend <= 1'b0;
      IBUS_REQ <= 1'b0;
      CPU_ERR  <= 1'b0;
      CPU_DO   <= '0;
      IBUS_A   <= '0;
      IBUS_DI  <= '0;
      IBUS_BA  <= '0;
      IBUS_WE  <= 1'b0;
`ifdef IBUS_TIMEOUT_EN
      wait_cnt <= '0;
`endif
    end else if (!RES_N) begin
      // Soft reset acts on the next clock, independent of CE_R and EN.
      state    <= S_IDLE;
      err_pend <= 1'b0;
      IBUS_REQ <= 1'b0;
      CPU_ERR  <= 1'b0;
      CPU_DO   <= '0;
      IBUS_A   <= '0;
      IBUS_DI  <= '0;
      IBUS_BA  <= '0;
      IBUS_WE  <= 1'b0;
`ifdef IBUS_TIMEOUT_EN
      wait_cnt <= '0;
`endif
    end else if (EN && CE_R) begin
      case (state)
        S_IDLE: begin
          if (CPU_REQ) begin
            IBUS_A   <= CPU_A;
            IBUS_DI  <= CPU_DI;
            IBUS_BA  <= CPU_BA;
            IBUS_WE  <= CPU_WE;
            IBUS_REQ <= 1'b1;
            err_pend <= 1'b0;
            state    <= S_REQ;
          end
        end

        // One tick so the slot sees the REQ rising edge and raises BUSY.
        S_REQ: state <= S_WAIT;

        S_WAIT: begin
          if (!hit_any) begin
            CPU_DO   <= '1;
            CPU_ERR  <= 1'b1;
            IBUS_REQ <= 1'b0;
            state    <= S_DONE;
          end else if (!sel_busy) begin
            // Writes leave CPU_DO alone; the falling REQ commits them.
            if (!IBUS_WE) CPU_DO <= sel_do;
            CPU_ERR  <= hit_multi || err_pend;
            IBUS_REQ <= 1'b0;
            state    <= S_DONE;
`ifdef IBUS_TIMEOUT_EN
          end else if (wait_cnt == TMO_LAST) begin
            CPU_DO   <= '1;
            CPU_ERR  <= 1'b1;
            IBUS_REQ <= 1'b0;
            state    <= S_DONE;
`endif
          end else begin
            err_pend <= err_pend || hit_multi;
`ifdef IBUS_TIMEOUT_EN
            wait_cnt <= wait_cnt + 8'd1;
`endif
          end
        end

        // CPU_BUSY is low for this tick; a request still present is only
        // accepted once back in IDLE.
        S_DONE: begin
          CPU_ERR <= 1'b0;
          state   <= S_IDLE;
`ifdef IBUS_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sh7604_ibus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sh7604_ibus_ctrl
//
// Directed-vector bench for sh7604_ibus_ctrl. One CE_R tick spans two clocks
// (CE_R high for one, low for the next) so the enable gating is exercised on
// every step. Inputs change #1 after a rising edge; outputs are sampled there.
// Tick numbering in an access: tick 1 is the IDLE tick that accepts the
// request, tick 2 is REQ, ticks 3.. are WAIT; the access returns the tick
// number after which CPU_BUSY was first seen low (the DONE tick).
// -----------------------------------------------------------------------------
module tb_sh7604_ibus_ctrl;

  localparam int NP = 8;

  logic          CLK = 1'b0;
  logic          RST_N, CE_R, CE_F, EN, RES_N;
  logic [31:0]   CPU_A, CPU_DI;
  logic [3:0]    CPU_BA;
  logic          CPU_WE, CPU_REQ;
  logic [31:0]   CPU_DO;
  logic          CPU_BUSY, CPU_ERR;
  logic [31:0]   IBUS_A, IBUS_DI;
  logic [3:0]    IBUS_BA;
  logic          IBUS_WE, IBUS_REQ;
  logic [32*NP-1:0] PER_DO;
  logic [NP-1:0] PER_BUSY, PER_ACT;

  int n_vec  = 0;
  int n_miss = 0;

  sh7604_ibus_ctrl #(.NUM_PER(NP), .TIMEOUT_CYC(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .CE_F(CE_F), .EN(EN), .RES_N(RES_N),
    .CPU_A(CPU_A), .CPU_DI(CPU_DI), .CPU_BA(CPU_BA), .CPU_WE(CPU_WE), .CPU_REQ(CPU_REQ),
    .CPU_DO(CPU_DO), .CPU_BUSY(CPU_BUSY), .CPU_ERR(CPU_ERR),
    .IBUS_A(IBUS_A), .IBUS_DI(IBUS_DI), .IBUS_BA(IBUS_BA), .IBUS_WE(IBUS_WE),
    .IBUS_REQ(IBUS_REQ),
    .PER_DO(PER_DO), .PER_BUSY(PER_BUSY), .PER_ACT(PER_ACT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One CE_R tick: an enabled clock followed by a gated clock.
  task automatic tick();
    @(negedge CLK) CE_R = 1'b1;
    @(posedge CLK) #1;
    @(negedge CLK) CE_R = 1'b0;
    @(posedge CLK) #1;
  endtask

  // Issue one access. busy_k > 0: selected slot busy for the first busy_k WAIT
  // ticks; busy_k == 0: never busy; busy_k < 0: stuck busy. done_n = 0 when the
  // budget ran out (CPU_REQ is then left high and the access left pending).
  // On completion CPU_REQ is dropped and one more tick is run.
  task automatic run_access(
    input  logic [31:0] a, input logic [31:0] di, input logic [3:0] ba, input logic we,
    input  logic [NP-1:0] act, input int busy_slot, input int busy_k, input int budget,
    output int done_n, output int req_hi, output bit di_stable,
    output logic [31:0] do_v, output logic err_v,
    output logic err_after, output logic req_after);
    done_n = 0; req_hi = 0; di_stable = 1'b1;
    do_v = '0; err_v = 1'b0; err_after = 1'b0; req_after = 1'b0;
    CPU_A = a; CPU_DI = di; CPU_BA = ba; CPU_WE = we; CPU_REQ = 1'b1;
    PER_ACT = act;
    for (int n = 1; n <= budget; n++) begin
      PER_BUSY = '0;
      if (busy_k < 0 || (busy_k > 0 && n <= busy_k + 2)) PER_BUSY[busy_slot] = 1'b1;
      tick();
      if (IBUS_REQ) begin
        req_hi++;
        if (IBUS_DI !== di) di_stable = 1'b0;
      end
      if (!CPU_BUSY) begin
        done_n = n; do_v = CPU_DO; err_v = CPU_ERR;
        break;
      end
    end
    if (done_n != 0) begin
      CPU_REQ = 1'b0; PER_BUSY = '0;
      tick();
      err_after = CPU_ERR; req_after = IBUS_REQ;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int done_n, req_hi;
    bit di_stable;
    logic [31:0] do_v;
    logic err_v, err_after, req_after;

    RST_N = 1'b0; CE_R = 1'b0; CE_F = 1'b0; EN = 1'b1; RES_N = 1'b1;
    CPU_A = '0; CPU_DI = '0; CPU_BA = '0; CPU_WE = 1'b0; CPU_REQ = 1'b0;
    PER_DO = '0; PER_BUSY = '0; PER_ACT = '0;
    PER_DO[32*0 +: 32] = 32'h1111_1111;
    PER_DO[32*1 +: 32] = 32'hA5A5_0001;
    PER_DO[32*2 +: 32] = 32'h1F1F_1F1F;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_ibus_req", {31'b0, IBUS_REQ}, 32'd0);
    check("rst_cpu_busy", {31'b0, CPU_BUSY}, 32'd0);
    check("rst_cpu_err",  {31'b0, CPU_ERR},  32'd0);
    check("rst_cpu_do",   CPU_DO,            32'd0);
    check("rst_ibus_a",   IBUS_A,            32'd0);
    RST_N = 1'b1;
    tick(); tick();
    check("idle_ibus_req", {31'b0, IBUS_REQ}, 32'd0);

    // Read, slot 2, busy for two WAIT ticks -> DONE on tick 5.
    run_access(32'hFFFF_FE80, 32'h0, 4'hF, 1'b0, 8'b0000_0100, 2, 2, 50,
               done_n, req_hi, di_stable, do_v, err_v, err_after, req_after);
    check("rd_done_tick", done_n,             32'd5);
    check("rd_cpu_do",    do_v,               32'h1F1F_1F1F);
    check("rd_cpu_err",   {31'b0, err_v},     32'd0);
    check("rd_req_after", {31'b0, req_after}, 32'd0);
    check("rd_ibus_a",    IBUS_A,             32'hFFFF_FE80);
    check("rd_ibus_we",   {31'b0, IBUS_WE},   32'd0);

    // Write, slot 2 never busy: REQ high for REQ and WAIT only, CPU_DO kept.
    run_access(32'hFFFF_FE84, 32'h0000_5A55, 4'b1100, 1'b1, 8'b0000_0100, 2, 0, 50,
               done_n, req_hi, di_stable, do_v, err_v, err_after, req_after);
    check("wr_done_tick", done_n,               32'd3);
    check("wr_req_ticks", req_hi,               32'd2);
    check("wr_di_stable", {31'b0, di_stable},   32'd1);
    check("wr_cpu_do",    do_v,                 32'h1F1F_1F1F);
    check("wr_cpu_err",   {31'b0, err_v},       32'd0);
    check("wr_ibus_ba",   {28'b0, IBUS_BA},     32'hC);
    check("wr_ibus_we",   {31'b0, IBUS_WE},     32'd1);

    // Unmapped read: all-ones data, error pulse only in the DONE tick.
    run_access(32'h0000_1000, 32'h0, 4'hF, 1'b0, 8'b0000_0000, 0, 0, 50,
               done_n, req_hi, di_stable, do_v, err_v, err_after, req_after);
    check("um_done_tick", done_n,              32'd3);
    check("um_cpu_do",    do_v,                32'hFFFF_FFFF);
    check("um_err_pulse", {31'b0, err_v},      32'd1);
    check("um_err_after", {31'b0, err_after},  32'd0);
    check("um_busy_after",{31'b0, CPU_BUSY},   32'd0);

    // Multi-hit on slots 0 and 2: slot 0 data, error flagged.
    PER_DO[32*2 +: 32] = 32'h2222_2222;
    run_access(32'hFFFF_FE00, 32'h0, 4'hF, 1'b0, 8'b0000_0101, 0, 0, 50,
               done_n, req_hi, di_stable, do_v, err_v, err_after, req_after);
    check("mh_done_tick", done_n,             32'd3);
    check("mh_cpu_do",    do_v,               32'h1111_1111);
    check("mh_cpu_err",   {31'b0, err_v},     32'd1);
    check("mh_err_after", {31'b0, err_after}, 32'd0);

    // EN low after the IDLE tick: REQ state and IBUS_REQ frozen.
    CPU_A = 32'hFFFF_FE10; CPU_DI = '0; CPU_BA = 4'hF; CPU_WE = 1'b0; CPU_REQ = 1'b1;
    PER_ACT = 8'b0000_0010; PER_BUSY = '0;
    tick();
    EN = 1'b0;
    tick(); tick(); tick();
    check("en_hold_req",  {31'b0, IBUS_REQ}, 32'd1);
    check("en_hold_busy", {31'b0, CPU_BUSY}, 32'd1);
    EN = 1'b1;
    tick();
    check("en_wait_busy", {31'b0, CPU_BUSY}, 32'd1);
    tick();
    check("en_done_busy", {31'b0, CPU_BUSY}, 32'd0);
    check("en_cpu_do",    CPU_DO,            32'hA5A5_0001);
    CPU_REQ = 1'b0;
    tick();

    // Slot stuck busy.
`ifdef IBUS_TIMEOUT_EN
    run_access(32'hFFFF_FE20, 32'h0, 4'hF, 1'b0, 8'b0000_0010, 1, -1, 50,
               done_n, req_hi, di_stable, do_v, err_v, err_after, req_after);
    check("to_done_tick", done_n,             32'd6);
    check("to_cpu_do",    do_v,               32'hFFFF_FFFF);
    check("to_cpu_err",   {31'b0, err_v},     32'd1);
    check("to_err_after", {31'b0, err_after}, 32'd0);
`else
    run_access(32'hFFFF_FE20, 32'h0, 4'hF, 1'b0, 8'b0000_0010, 1, -1, 1000,
               done_n, req_hi, di_stable, do_v, err_v, err_after, req_after);
    check("stuck_no_done", done_n,             32'd0);
    check("stuck_busy",    {31'b0, CPU_BUSY},  32'd1);
    check("stuck_ibus_req",{31'b0, IBUS_REQ},  32'd1);
    CPU_REQ = 1'b0;
    RES_N = 1'b0;
    @(posedge CLK) #1;
    RES_N = 1'b1;
`endif

    // RES_N pulsed low while in WAIT (tick 3, slot stuck busy).
    run_access(32'hFFFF_FE30, 32'h0, 4'hF, 1'b0, 8'b0000_0010, 1, -1, 3,
               done_n, req_hi, di_stable, do_v, err_v, err_after, req_after);
    check("rs_in_wait", {31'b0, IBUS_REQ}, 32'd1);
    CPU_REQ = 1'b0; RES_N = 1'b0;
    @(posedge CLK) #1;
    check("rs_ibus_req", {31'b0, IBUS_REQ}, 32'd0);
    check("rs_cpu_busy", {31'b0, CPU_BUSY}, 32'd0);
    check("rs_cpu_do",   CPU_DO,            32'd0);
    RES_N = 1'b1; PER_BUSY = '0;
    tick();

    // Normal access after the soft reset.
    run_access(32'hFFFF_FE40, 32'h0, 4'hF, 1'b0, 8'b0000_0010, 1, 1, 50,
               done_n, req_hi, di_stable, do_v, err_v, err_after, req_after);
    check("post_done_tick", done_n,         32'd4);
    check("post_cpu_do",    do_v,           32'hA5A5_0001);
    check("post_cpu_err",   {31'b0, err_v}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/sh7604_ibus_ctrl.md
Name: sh7604_ibus_ctrl

Overview:
- On-chip peripheral bus (IBUS) access controller for the SH7604 core.
- Accepts one CPU-side access at a time and broadcasts it to NUM_PER peripheral slots (WDT, FRT, SCI, DMAC, ...).
- Sequences the REQ/BUSY/ACT handshake those peripherals expect: writes commit on REQ falling edge; read data is registered by the peripheral on CE_F.
- Returns data, stall and error status to the CPU.

Parameters:
- NUM_PER, 8, number of peripheral slots (1..16).
- TIMEOUT_CYC, 255, CE_R ticks allowed in WAIT before abort (IBUS_TIMEOUT_EN only); 8-bit counter.

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- CE_R  in  1  rising-phase clock enable; FSM advances only here
- CE_F  in  1  falling-phase clock enable (unused internally; gates nothing, kept for slot symmetry)
- EN  in  1  global enable; FSM frozen when 0
- RES_N  in  1  synchronous soft reset, active low
- CPU_A  in  32  access address
- CPU_DI  in  32  write data
- CPU_BA  in  4  byte lanes
- CPU_WE  in  1  1 = write
- CPU_REQ  in  1  access request, level, held until CPU_BUSY low
- CPU_DO  out  32  read data
- CPU_BUSY  out  1  stall
- CPU_ERR  out  1  one-tick pulse: unmapped, multi-hit or timeout
- IBUS_A  out  32  latched address
- IBUS_DI  out  32  latched write data
- IBUS_BA  out  4  latched lanes
- IBUS_WE  out  1  latched direction
- IBUS_REQ  out  1  request to all slots
- PER_DO  in  32*NUM_PER  packed slot read data (slot i at [32i+31:32i])
- PER_BUSY  in  NUM_PER  slot busy
- PER_ACT  in  NUM_PER  slot address-decode hit

Behaviour:
- Reset (RST_N low or RES_N low): state IDLE; IBUS_REQ=0; CPU_BUSY=0; CPU_ERR=0; CPU_DO=0; IBUS_A/DI/BA/WE=0; timeout counter=0.
- All state changes occur on CLK edges with EN && CE_R. Between ticks, outputs hold.
- CPU_BUSY is combinational: CPU_REQ && state!=DONE || state in {REQ, WAIT}. The CPU therefore never sees a free cycle before completion.
- IDLE:
  - On CPU_REQ: latch CPU_A/DI/BA/WE onto IBUS_*; IBUS_REQ<=1; go to REQ.
- REQ: one tick so the slot sees the REQ rising edge and raises BUSY. Go to WAIT.
- WAIT: hit vector H = PER_ACT.
  - H==0: CPU_DO<=FFFFFFFF, CPU_ERR<=1, IBUS_REQ<=0, go to DONE.
  - More than one bit set: select the lowest index and set CPU_ERR<=1. The access otherwise proceeds.
  - Selected slot PER_BUSY==0: CPU_DO<=selected PER_DO (all 32 bits, lane replication is the slot's job); IBUS_REQ<=0; go to DONE.
  - Else stay; counter increments.
- DONE: CPU_BUSY low for this tick. The falling IBUS_REQ lets the slot commit the write. Clear counter; go to IDLE.
  - A CPU_REQ still high in this tick is treated as a new access only from IDLE (minimum 4 ticks per access: IDLE, REQ, WAIT, DONE).
- Writes: CPU_DO is left unchanged, except for the error value FFFFFFFF.
- CPU_ERR pulses for exactly one CE_R tick (the DONE tick).
- IBUS_A/DI/BA/WE are held stable from IDLE exit through DONE. They never change while IBUS_REQ=1.
- CPU_REQ dropping mid-access is ignored; the access completes.
- RES_N low mid-access: immediate return to IDLE with IBUS_REQ=0. The slot sees REQ fall; its own RES_N has already cleared it.
- EN low freezes the state and IBUS_REQ level.

Optional Feature:
- IBUS_TIMEOUT_EN defined: in WAIT, when the counter reaches TIMEOUT_CYC with the selected BUSY still 1, the block aborts:
  - IBUS_REQ<=0, CPU_DO<=FFFFFFFF, CPU_ERR<=1, go to DONE.
- Undefined: no counter logic; WAIT waits indefinitely.

Test Plan:
- Read: CPU_A=FFFFFE80, slot 2 ACT, BUSY high for 2 ticks after REQ, DO=1F1F1F1F -> CPU_DO=1F1F1F1F, CPU_BUSY low in DONE tick 5 ticks after request, CPU_ERR=0.
- Write: CPU_DI=00005A55, BA=1100, slot 2 BUSY never set -> IBUS_REQ high exactly 2 ticks (REQ, WAIT), IBUS_DI stable throughout, CPU_DO unchanged.
- Unmapped: PER_ACT=0 -> CPU_DO=FFFFFFFF, CPU_ERR one-tick pulse, total 4 ticks.
- Multi-hit: PER_ACT=00000101b, slot0 DO=11111111, slot2 DO=22222222 -> CPU_DO=11111111, CPU_ERR=1.
- Timeout (IBUS_TIMEOUT_EN, TIMEOUT_CYC=4): slot BUSY stuck 1 -> abort on 4th WAIT tick, CPU_DO=FFFFFFFF, CPU_ERR=1. Without the macro -> CPU_BUSY stays high for 1000 ticks.
- RES_N pulsed low in WAIT -> IBUS_REQ=0 next edge, state IDLE, CPU_BUSY=0; next request completes normally.
